// File: rtl/multi_lane_acc.sv
// Purpose : multi-channel accumulate/reduce unit. It supports ADD, SUB, LOAD and
//           REDUCE on CHANNELS independent accumulators. The result goes to a
//           one-entry output register with a valid/ready handshake.
// Latency : an op that fires in cycle N presents sum/cout/red/ch_out with
//           out_valid=1 in cycle N+1.
// Backpr. : in_ready = ~clr & (~out_valid | out_ready). The output register holds
//           steady while out_valid & ~out_ready. A pop and a fire in the same
//           cycle reload the register, so a stream runs at one op per cycle.
// Ports   : clk, rst (synchronous, active-high), clr (clears all accumulators),
//           in_valid/in_ready/ch_sel/mode/x/cin (request side),
//           out_valid/out_ready/sum/cout/red/ch_out (result side).
module multi_lane_acc #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHW-1:0]   ch_sel,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] x,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [2:0]       red,
  output logic [CHW-1:0]   ch_out
);

  localparam logic [1:0] MODE_ADD    = 2'b00;
  localparam logic [1:0] MODE_SUB    = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;
  localparam logic [1:0] MODE_REDUCE = 2'b11;

  logic [WIDTH-1:0] acc [CHANNELS];

  logic             fire;
  logic             ch_ok;
  logic [WIDTH-1:0] a;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH-1:0] r;
  logic             c;
  logic             wr_en;

  assign in_ready = ~clr & (~out_valid | out_ready);
  assign fire     = in_valid & in_ready;

  // Channel read mux. A code that matches no accumulator reads as zero, and
  // ch_ok stays low so that code degrades to a REDUCE of 0.
  always_comb begin
    a     = '0;
    ch_ok = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == CHW'(i)) begin
        a     = acc[i];
        ch_ok = 1'b1;
      end
    end
  end

  // The WIDTH+1-bit forms give the carry directly. For SUB, the top bit is the
  // sign of a - x - cin, which is the borrow out.
  assign add_ext = {1'b0, a} + {1'b0, x} + {{WIDTH{1'b0}}, cin};
  assign sub_ext = {1'b0, a} - {1'b0, x} - {{WIDTH{1'b0}}, cin};

  always_comb begin
    r     = a;
    c     = 1'b0;
    wr_en = 1'b0;
    if (ch_ok) begin
      unique case (mode)
        MODE_ADD: begin
          r     = add_ext[WIDTH-1:0];
          c     = add_ext[WIDTH];
          wr_en = 1'b1;
        end
        MODE_SUB: begin
          r     = sub_ext[WIDTH-1:0];
          c     = sub_ext[WIDTH];
          wr_en = 1'b1;
        end
        MODE_LOAD: begin
          r     = x;
          wr_en = 1'b1;
        end
        MODE_REDUCE: begin
          r = a;
        end
        default: begin
          r = a;
        end
      endcase
    end else begin
      r = '0;
    end
  end

  // Accumulators. clr deasserts in_ready, so a clear never coincides with a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else if (fire && wr_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ch_sel == CHW'(i)) acc[i] <= r;
      end
    end
  end

  // One-entry output buffer. The data fields are loaded only on fire, so they
  // stay frozen while the consumer stalls and after a plain pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      red       <= 3'b000;
      ch_out    <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      sum       <= r;
      cout      <= c;
      red       <= {^r, |r, &r};
      ch_out    <= ch_sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_lane_acc.sv
module tb_multi_lane_acc;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [1:0] ch_sel, ch_out, mode;
  logic [7:0] x, sum;
  logic [2:0] red;

  int checks = 0;
  int errors = 0;

  // Reference model: arithmetic done on plain integers.
  int macc [4];
  bit exp_v;
  int exp_sum, exp_cout, exp_red, exp_ch;

  multi_lane_acc #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .ch_sel(ch_sel), .mode(mode), .x(x), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .red(red), .ch_out(ch_out)
  );

  always #5 clk = ~clk;

  function automatic int red_of(int v);
    int ones = 0;
    for (int b = 0; b < 8; b++) ones += (v >> b) & 1;
    return ((ones % 2) << 2) | ((v != 0) << 1) | (v == 255 ? 1 : 0);
  endfunction

  task automatic drive(bit v, int m, int ch, int xv, bit ci);
    in_valid = v; mode = 2'(m); ch_sel = 2'(ch); x = 8'(xv); cin = ci;
  endtask

  // Advance one clock and update the model with the inputs that were present at the edge.
  task automatic step();
    bit f;
    int a, t, r, co;
    f = !rst && in_valid && !clr && (!exp_v || out_ready);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) macc[i] = 0;
      exp_v = 0; exp_sum = 0; exp_cout = 0; exp_red = 0; exp_ch = 0;
    end else begin
      if (clr) for (int i = 0; i < 4; i++) macc[i] = 0;
      if (f) begin
        a = macc[ch_sel]; co = 0;
        case (mode)
          2'b00: begin t = a + x + cin; r = t % 256; co = (t > 255); macc[ch_sel] = r; end
          2'b01: begin t = a - x - cin; r = (t + 512) % 256; co = (t < 0); macc[ch_sel] = r; end
          2'b10: begin r = x; macc[ch_sel] = r; end
          default: r = a;
        endcase
        exp_v = 1; exp_sum = r; exp_cout = co; exp_red = red_of(r); exp_ch = ch_sel;
      end else if (out_ready) begin
        exp_v = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; clr = 0; out_ready = 1; drive(0, 0, 0, 0, 0);
    step(); step();
    rst = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if ({sum, cout, red, ch_out} !== 14'd0) begin errors++; $display("FAIL reset_outs: got sum=%h cout=%b red=%b ch=%0d want all 0", sum, cout, red, ch_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_sub();
    drive(1, 0, 0, 'hF0, 0); step();
    checks++; if (out_valid !== 1'b1 || sum !== 8'hF0 || cout !== 1'b0 || ch_out !== 2'd0) begin errors++; $display("FAIL add1: got v=%b sum=%h cout=%b ch=%0d want 1 f0 0 0", out_valid, sum, cout, ch_out); end
    drive(1, 0, 0, 'h20, 1); step();
    checks++; if (sum !== 8'h11 || cout !== 1'b1) begin errors++; $display("FAIL add_carry: got sum=%h cout=%b want 11 1", sum, cout); end
    drive(1, 2, 1, 'h05, 0); step();
    checks++; if (sum !== 8'h05 || cout !== 1'b0 || ch_out !== 2'd1) begin errors++; $display("FAIL load: got sum=%h cout=%b ch=%0d want 05 0 1", sum, cout, ch_out); end
    drive(1, 1, 1, 'h06, 0); step();
    checks++; if (sum !== 8'hFF || cout !== 1'b1 || red !== 3'b011) begin errors++; $display("FAIL sub_borrow: got sum=%h cout=%b red=%b want ff 1 011", sum, cout, red); end
    drive(0, 0, 0, 0, 0); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 0; drive(1, 0, 2, 3, 0); step();
    drive(1, 0, 3, 7, 0); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (out_valid !== 1'b1 || sum !== 8'h03 || ch_out !== 2'd2) begin errors++; $display("FAIL bp_hold: got v=%b sum=%h ch=%0d want 1 03 2", out_valid, sum, ch_out); end
    end
    out_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || sum !== 8'h07 || ch_out !== 2'd3) begin errors++; $display("FAIL bp_reload: got v=%b sum=%h ch=%0d want 1 07 3", out_valid, sum, ch_out); end
    drive(0, 0, 0, 0, 0); step();
  endtask

  task automatic test_stream();
    rst = 1; step(); rst = 0; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, i % 4, 1, 0); step();
      checks++; if (out_valid !== 1'b1 || ch_out !== 2'(i % 4) || sum !== 8'(i / 4 + 1)) begin errors++; $display("FAIL stream%0d: got v=%b ch=%0d sum=%h want 1 %0d %0h", i, out_valid, ch_out, sum, i % 4, i / 4 + 1); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, i, 0, 0); step();
      checks++; if (sum !== 8'h02 || cout !== 1'b0) begin errors++; $display("FAIL stream_acc%0d: got sum=%h cout=%b want 02 0", i, sum, cout); end
    end
    drive(0, 0, 0, 0, 0); step();
  endtask

  task automatic test_clr();
    out_ready = 0; drive(1, 2, 2, 'h5A, 0); step();
    clr = 1; drive(1, 0, 0, 1, 0); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready: got %b want 0", in_ready); end
    step(); clr = 0;
    checks++; if (out_valid !== 1'b1 || sum !== 8'h5A || ch_out !== 2'd2) begin errors++; $display("FAIL clr_pending: got v=%b sum=%h ch=%0d want 1 5a 2", out_valid, sum, ch_out); end
    out_ready = 1; drive(1, 3, 2, 0, 0); step();
    checks++; if (out_valid !== 1'b1 || sum !== 8'h00 || red !== 3'b000 || ch_out !== 2'd2) begin errors++; $display("FAIL clr_reduce: got v=%b sum=%h red=%b ch=%0d want 1 00 000 2", out_valid, sum, red, ch_out); end
  endtask

  task automatic test_rst_mid();
    drive(1, 2, 1, 'h9C, 0); step();
    drive(0, 0, 0, 0, 0); out_ready = 0; step();
    rst = 1; step(); rst = 0; out_ready = 1;
    checks++; if (out_valid !== 1'b0 || {sum, cout, red, ch_out} !== 14'd0) begin errors++; $display("FAIL rst_mid: got v=%b sum=%h cout=%b red=%b ch=%0d want all 0", out_valid, sum, cout, red, ch_out); end
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, i, 0, 0); step();
      checks++; if (sum !== 8'h00 || ch_out !== 2'(i)) begin errors++; $display("FAIL rst_acc%0d: got sum=%h ch=%0d want 00 %0d", i, sum, ch_out, i); end
    end
    drive(0, 0, 0, 0, 0); step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 15) == 0;
      #1;
      checks++; if (in_ready !== (!clr && (!exp_v || out_ready))) begin errors++; $display("FAIL rnd_in_ready@%0d: got %b want %b", n, in_ready, !clr && (!exp_v || out_ready)); end
      step();
      checks++;
      if (out_valid !== exp_v || sum !== 8'(exp_sum) || cout !== 1'(exp_cout) || red !== 3'(exp_red) || ch_out !== 2'(exp_ch)) begin
        errors++;
        $display("FAIL rnd_out@%0d: got v=%b sum=%h cout=%b red=%b ch=%0d want %b %h %0d %b %0d", n, out_valid, sum, cout, red, ch_out, exp_v, exp_sum, exp_cout, 3'(exp_red), exp_ch);
      end
    end
    clr = 0;
  endtask

  initial begin
    exp_v = 0;
    test_reset();
    test_add_sub();
    test_backpressure();
    test_stream();
    test_clr();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
